// File: rtl/qif_pkg.sv
// -----------------------------------------------------------------------------
// qif_pkg
//   Shared definitions for the time-multiplexed QIF neuron array:
//   membrane/sum widths, default reset and threshold potentials, the
//   scheduler FSM state type, and the sat8 clamp used by the update math.
// -----------------------------------------------------------------------------
package qif_pkg;

   localparam int V_W   = 8;    // membrane potential / current width
   localparam int SUM_W = 11;   // V + (V/8)^2 + I/4 fits in 11b signed

   localparam logic signed [V_W-1:0] QIF_V_RESET = -8'sd20;
   localparam logic signed [V_W-1:0] QIF_V_TH    = 8'sd50;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      EMIT   = 2'd2,
      DONE   = 2'd3
   } qif_state_e;

   // Clamp an 11-bit signed sum into the 8-bit membrane range (no wrap).
   function automatic logic signed [V_W-1:0] sat8(input logic signed [SUM_W-1:0] x);
      logic signed [V_W-1:0] r;
      if (x > 11'sd127) begin
         r = 8'sd127;
      end else if (x < -11'sd128) begin
         r = -8'sd128;
      end else begin
         r = x[V_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/qif_update_core.sv
// -----------------------------------------------------------------------------
// qif_update_core
//   Purely combinational QIF membrane update, shared by neuron arrays.
//   Ports:
//     v      in  8b signed  stored membrane potential
//     i      in  8b signed  synaptic current
//     v_next out 8b signed  V_RESET when firing, else sat8(V + (V/8)^2 + I/4)
//     fire   out 1b         stored V is at or above threshold
// -----------------------------------------------------------------------------
module qif_update_core
   import qif_pkg::*;
#(
   parameter logic signed [V_W-1:0] V_RESET = QIF_V_RESET,
   parameter logic signed [V_W-1:0] V_TH    = QIF_V_TH
)(
   input  logic signed [V_W-1:0] v,
   input  logic signed [V_W-1:0] i,
   output logic signed [V_W-1:0] v_next,
   output logic                  fire
);

   logic signed [SUM_W-1:0] v_ext;
   logic signed [SUM_W-1:0] i_ext;
   logic signed [SUM_W-1:0] v_div8;
   logic signed [SUM_W-1:0] i_div4;
   logic signed [SUM_W-1:0] v_sq;
   logic signed [SUM_W-1:0] sum;

   assign v_ext  = $signed({{(SUM_W-V_W){v[V_W-1]}}, v});
   assign i_ext  = $signed({{(SUM_W-V_W){i[V_W-1]}}, i});

   // Signed division truncates toward zero, so -12/8 = -1 (not -2).
   assign v_div8 = v_ext / 11'sd8;
   assign i_div4 = i_ext / 11'sd4;
   assign v_sq   = v_div8 * v_div8;           // 0..256, fits in 11b
   assign sum    = v_ext + v_sq + i_div4;

   // Threshold uses the stored value, before integration.
   assign fire   = (v >= V_TH);
   assign v_next = fire ? V_RESET : sat8(sum);

endmodule

// File: rtl/qif_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// qif_neuron_scheduler
//   Sweeps NUM_NEURONS QIF neurons through one shared update core, one neuron
//   per cycle per tick, and emits spikes as a valid/ready event stream.
//   Ports:
//     clk, reset     clock (rising edge), asynchronous active-high reset
//     tick           1-cycle pulse that starts a sweep (snapshots i_syn)
//     i_syn          packed signed currents, neuron k at [8k+7:8k]
//     spike_valid/spike_ready/spike_id   spike event handshake
//     busy           sweep in progress
//     sweep_done     1-cycle pulse after the last neuron is written
//     tick_overrun   sticky: tick seen while not IDLE
//     mon_sel/v_mon  combinational read of one membrane potential
// -----------------------------------------------------------------------------
module qif_neuron_scheduler
   import qif_pkg::*;
#(
   parameter int                    NUM_NEURONS = 4,
   parameter logic signed [V_W-1:0] V_RESET     = QIF_V_RESET,
   parameter logic signed [V_W-1:0] V_TH        = QIF_V_TH,
   parameter int                    IDW         = $clog2(NUM_NEURONS)
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         tick,
   input  logic [V_W*NUM_NEURONS-1:0]   i_syn,
   output logic                         spike_valid,
   input  logic                         spike_ready,
   output logic [IDW-1:0]               spike_id,
   output logic                         busy,
   output logic                         sweep_done,
   output logic                         tick_overrun,
   input  logic [IDW-1:0]               mon_sel,
   output logic signed [V_W-1:0]        v_mon
);

   qif_state_e                   state_q, state_d;
   logic [IDW-1:0]               idx_q, idx_d;
   logic [V_W*NUM_NEURONS-1:0]   isnap_q, isnap_d;
   logic signed [V_W-1:0]        v_mem_q [NUM_NEURONS];
   logic signed [V_W-1:0]        v_mem_d [NUM_NEURONS];
   logic                         spike_valid_q, spike_valid_d;
   logic [IDW-1:0]               spike_id_q, spike_id_d;
   logic                         overrun_q, overrun_d;

   logic signed [V_W-1:0]        i_arr [NUM_NEURONS];
   logic signed [V_W-1:0]        v_cur;
   logic signed [V_W-1:0]        i_cur;
   logic signed [V_W-1:0]        core_v_next;
   logic                         core_fire;
   logic                         last_idx;

   // Unpack the snapshot so the current neuron's input is a simple array read.
   for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_unpack
      assign i_arr[gi] = i_syn_slice(isnap_q, gi);
   end

   function automatic logic signed [V_W-1:0] i_syn_slice(
      input logic [V_W*NUM_NEURONS-1:0] vec,
      input int                         k
   );
      return vec[V_W*k +: V_W];
   endfunction

   assign v_cur    = v_mem_q[idx_q];
   assign i_cur    = i_arr[idx_q];
   assign last_idx = (idx_q == IDW'(NUM_NEURONS-1));

   qif_update_core #(
      .V_RESET (V_RESET),
      .V_TH    (V_TH)
   ) u_core (
      .v      (v_cur),
      .i      (i_cur),
      .v_next (core_v_next),
      .fire   (core_fire)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      isnap_d       = isnap_q;
      v_mem_d       = v_mem_q;
      spike_valid_d = spike_valid_q;
      spike_id_d    = spike_id_q;
      // DONE is still busy, so a tick there is an overrun as well.
      overrun_d     = overrun_q | (tick && (state_q != IDLE));

      unique case (state_q)
         IDLE: begin
            if (tick) begin
               isnap_d = i_syn;
               idx_d   = '0;
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            v_mem_d[idx_q] = core_v_next;
            if (core_fire) begin
               // Index is held in EMIT so the sweep resumes at idx+1 on accept.
               spike_valid_d = 1'b1;
               spike_id_d    = idx_q;
               state_d       = EMIT;
            end else if (last_idx) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDW'(1);
            end
         end
         EMIT: begin
            if (spike_valid_q && spike_ready) begin
               spike_valid_d = 1'b0;
               if (last_idx) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IDW'(1);
                  state_d = UPDATE;
               end
            end
         end
         DONE: begin
            idx_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         isnap_q       <= '0;
         spike_valid_q <= 1'b0;
         spike_id_q    <= '0;
         overrun_q     <= 1'b0;
         for (int k = 0; k < NUM_NEURONS; k++) begin
            v_mem_q[k] <= V_RESET;
         end
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         isnap_q       <= isnap_d;
         spike_valid_q <= spike_valid_d;
         spike_id_q    <= spike_id_d;
         overrun_q     <= overrun_d;
         v_mem_q       <= v_mem_d;
      end
   end

   assign spike_valid  = spike_valid_q;
   assign spike_id     = spike_id_q;
   assign busy         = (state_q != IDLE);
   assign sweep_done   = (state_q == DONE);
   assign tick_overrun = overrun_q;
   // Out-of-range selects (non power-of-two arrays) read as zero.
   assign v_mon        = ({1'b0, mon_sel} < (IDW+1)'(NUM_NEURONS)) ? v_mem_q[mon_sel] : '0;

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
module tb_qif_neuron_scheduler;

   localparam int N     = 4;
   localparam int IDW   = 2;
   localparam int V_RST = -20;
   localparam int V_THR = 50;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 tick;
   logic [8*N-1:0]       i_syn;
   logic                 spike_valid;
   logic                 spike_ready;
   logic [IDW-1:0]       spike_id;
   logic                 busy;
   logic                 sweep_done;
   logic                 tick_overrun;
   logic [IDW-1:0]       mon_sel;
   logic signed [7:0]    v_mon;

   logic signed [7:0]    c_v, c_i, c_vn;
   logic                 c_fire;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int vm [N];
   int exp_q [$];

   always #5 clk = ~clk;

   qif_neuron_scheduler #(.NUM_NEURONS(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .i_syn        (i_syn),
      .spike_valid  (spike_valid),
      .spike_ready  (spike_ready),
      .spike_id     (spike_id),
      .busy         (busy),
      .sweep_done   (sweep_done),
      .tick_overrun (tick_overrun),
      .mon_sel      (mon_sel),
      .v_mon        (v_mon)
   );

   qif_update_core u_core_chk (
      .v      (c_v),
      .i      (c_i),
      .v_next (c_vn),
      .fire   (c_fire)
   );

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   // Reference QIF update using plain integer arithmetic.
   function automatic int model(input int v, input int i);
      int s;
      s = v + (v / 8) * (v / 8) + i / 4;
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: one sweep's expected potentials and spike ids.
   task automatic model_sweep(input logic [8*N-1:0] ivec, output int nspk);
      nspk = 0;
      for (int k = 0; k < N; k++) begin
         logic signed [7:0] ib;
         ib = ivec[8*k +: 8];
         if (vm[k] >= V_THR) begin
            exp_q.push_back(k);
            vm[k] = V_RST;
            nspk++;
         end else begin
            vm[k] = model(vm[k], int'(ib));
         end
      end
   endtask

   task automatic pulse_tick(input logic [8*N-1:0] ivec);
      i_syn = ivec;
      tick  = 1'b1;
      step();
      tick  = 1'b0;
      // Snapshot must isolate the sweep from later input changes.
      i_syn = (8*N)'($urandom);
   endtask

   task automatic wait_done(input string tag, input int start, input int exp_lat);
      int lat;
      lat = start;
      while (!sweep_done && lat < 200) begin
         step();
         lat++;
      end
      if (!sweep_done) check({tag, "_timeout"}, 0, 1);
      else if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
   endtask

   task automatic check_all_v(input string tag);
      for (int k = 0; k < N; k++) begin
         mon_sel = IDW'(k);
         #1;
         check($sformatf("%s_v%0d", tag, k), v_mon, vm[k]);
      end
   endtask

   task automatic finish_sweep(input string tag);
      step();
      check({tag, "_busy"}, busy, 0);
      check({tag, "_spk_left"}, exp_q.size(), 0);
      check_all_v(tag);
   endtask

   task automatic run_sweep(input logic [8*N-1:0] ivec, input string tag);
      int nspk;
      model_sweep(ivec, nspk);
      pulse_tick(ivec);
      wait_done(tag, 1, N + 1 + nspk);
      finish_sweep(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick  = 1'b0;
      step();
      step();
      reset = 1'b0;
      exp_q.delete();
      for (int k = 0; k < N; k++) vm[k] = V_RST;
   endtask

   // Each accepted spike is compared against the next expected id.
   always @(negedge clk) begin
      if (!reset && spike_valid && spike_ready) begin
         if (exp_q.size() == 0) check("spike_extra", spike_id, -1);
         else check("spike_id", spike_id, exp_q.pop_front());
      end
   end

   initial begin
      int nspk;
      int v3_old;
      int cnt;
      int cv [6];
      int ci [6];
      reset       = 1'b1;
      tick        = 1'b0;
      i_syn       = '0;
      spike_ready = 1'b1;
      mon_sel     = '0;

      // Reset state and integration from rest with zero input.
      do_reset();
      check("rst_valid", spike_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", sweep_done, 0);
      check("rst_overrun", tick_overrun, 0);
      check("rst_id", spike_id, 0);
      check_all_v("rst");
      for (int t = 0; t < 3; t++) run_sweep('0, $sformatf("zero%0d", t));

      // Neuron 2 driven hard; fires on the 4th sweep.
      do_reset();
      for (int t = 0; t < 4; t++) run_sweep({8'd0, 8'd127, 8'd0, 8'd0}, $sformatf("drv%0d", t));

      // Same drive with the consumer stalled for 10 cycles.
      do_reset();
      for (int t = 0; t < 3; t++) run_sweep({8'd0, 8'd127, 8'd0, 8'd0}, $sformatf("pre%0d", t));
      v3_old = vm[3];
      spike_ready = 1'b0;
      model_sweep({8'd0, 8'd127, 8'd0, 8'd0}, nspk);
      pulse_tick({8'd0, 8'd127, 8'd0, 8'd0});
      cnt = 0;
      while (!spike_valid && cnt < 20) begin
         step();
         cnt++;
      end
      check("stall_valid", spike_valid, 1);
      check("stall_id", spike_id, 2);
      mon_sel = 2'd3;
      for (int c = 0; c < 10; c++) begin
         step();
         check("stall_hold_valid", spike_valid, 1);
         check("stall_hold_id", spike_id, 2);
         check("stall_busy", busy, 1);
         check("stall_v3", v_mon, v3_old);
      end
      spike_ready = 1'b1;
      wait_done("stall", 0, -1);
      finish_sweep("stall");

      // Second tick two cycles into a sweep is ignored but flagged.
      do_reset();
      model_sweep('0, nspk);
      pulse_tick('0);
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("ovr_flag", tick_overrun, 1);
      check("ovr_busy", busy, 1);
      wait_done("ovr", 3, N + 1);
      finish_sweep("ovr");
      run_sweep('0, "ovr_after");
      check("ovr_sticky", tick_overrun, 1);

      // Tick landing in the DONE cycle also counts as overrun.
      do_reset();
      model_sweep('0, nspk);
      pulse_tick('0);
      wait_done("dtick", 1, N + 1);
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("dtick_overrun", tick_overrun, 1);
      check("dtick_busy", busy, 0);
      step();
      check("dtick_busy2", busy, 0);
      check_all_v("dtick");

      // Strong positive drive, mass firing, then negative currents.
      do_reset();
      for (int t = 0; t < 3; t++) run_sweep({4{8'h7f}}, $sformatf("pos%0d", t));
      run_sweep({4{8'h80}}, "neg_fire");
      run_sweep({8'hff, 8'hfb, 8'h81, 8'h80}, "neg0");
      run_sweep({8'hff, 8'hfb, 8'h81, 8'h80}, "neg1");
      run_sweep({4{8'h7f}}, "pos_again");

      // Update core at the arithmetic boundaries (saturation, truncation, threshold).
      cv = '{-128, -128,  49,  50, 127, -9};
      ci = '{ 127, -128, 127, 127, 127, -1};
      for (int k = 0; k < 6; k++) begin
         c_v = 8'(cv[k]);
         c_i = 8'(ci[k]);
         #1;
         check($sformatf("core_fire%0d", k), c_fire, (cv[k] >= V_THR) ? 1 : 0);
         check($sformatf("core_vn%0d", k), c_vn, (cv[k] >= V_THR) ? V_RST : model(cv[k], ci[k]));
      end

      // Reset while a spike is stalled in EMIT.
      do_reset();
      for (int t = 0; t < 3; t++) run_sweep({8'd0, 8'd127, 8'd0, 8'd0}, $sformatf("rpre%0d", t));
      spike_ready = 1'b0;
      pulse_tick({8'd0, 8'd127, 8'd0, 8'd0});
      cnt = 0;
      while (!spike_valid && cnt < 20) begin
         step();
         cnt++;
      end
      check("remit_valid", spike_valid, 1);
      reset = 1'b1;
      #1;
      exp_q.delete();
      for (int k = 0; k < N; k++) vm[k] = V_RST;
      check("rabort_valid", spike_valid, 0);
      check("rabort_busy", busy, 0);
      check_all_v("rabort");
      step();
      check("rabort_busy_edge", busy, 0);
      check("rabort_valid_edge", spike_valid, 0);
      reset = 1'b0;
      spike_ready = 1'b1;
      run_sweep('0, "post_rst");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
